handshake_rr_arbiter: RTL and testbench
=======================================

HANDSHAKE_RR_ARBITER -- requirements
Module: handshake_rr_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_PORTS, default 4, giving the number of requester handshake ports (legal range 1..16).
REQ-002 The module SHALL have parameter DATA_BITS, default 8, giving the payload width per beat.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port s_valid, input, NUM_PORTS bits: per-requester beat valid.
REQ-006 The module SHALL have port s_ready, output, NUM_PORTS bits: per-requester beat accept.
REQ-007 The module SHALL have port s_data, input, NUM_PORTS*DATA_BITS bits: requester i payload at bits [i*DATA_BITS +: DATA_BITS].
REQ-008 The module SHALL have port s_last, input, NUM_PORTS bits: per-requester end-of-packet flag.
REQ-009 The module SHALL have port m_valid, output, 1 bit: shared output beat valid.
REQ-010 The module SHALL have port m_ready, input, 1 bit: downstream accept.
REQ-011 The module SHALL have port m_data, output, DATA_BITS bits: shared output payload.
REQ-012 The module SHALL have port m_last, output, 1 bit: end-of-packet of the output beat.
REQ-013 The module SHALL have port m_src, output, max(1,$clog2(NUM_PORTS)) bits: index of the requester that sourced the output beat.

Function
REQ-014 A transfer SHALL occur on a port exactly on a rising clk edge where its valid and ready are both 1.
REQ-015 The output stage SHALL be one register (m_valid/m_data/m_last/m_src); can_accept = !m_valid || m_ready.
REQ-016 While m_valid=1 and m_ready=0, m_data, m_last and m_src SHALL hold stable.
REQ-017 At most one s_ready bit SHALL be 1 in any cycle; s_ready may depend combinationally on s_valid and m_ready.
REQ-018 Control SHALL be a two-state FSM: ARB and LOCKED, plus a round-robin pointer ptr and a lock_port register.
REQ-019 In ARB, candidate = first index with s_valid=1 searching ptr, ptr+1, ... circularly modulo NUM_PORTS; s_ready[candidate] = can_accept; no candidate means all s_ready=0.
REQ-020 In ARB, an accepted beat with s_last=1 SHALL keep state ARB and set ptr = (candidate+1) mod NUM_PORTS.
REQ-021 In ARB, an accepted beat with s_last=0 SHALL set lock_port = candidate and go to LOCKED; ptr unchanged.
REQ-022 In LOCKED, only s_ready[lock_port] = can_accept; all other requesters SHALL be ignored regardless of s_valid.
REQ-023 In LOCKED, an accepted beat with s_last=1 SHALL go to ARB and set ptr = (lock_port+1) mod NUM_PORTS.
REQ-024 An accepted beat SHALL appear on m_valid/m_data/m_last/m_src on the next cycle (latency 1).
REQ-025 If m_ready=1 and a new beat is accepted in the same cycle, the output register SHALL be overwritten with the new beat (1 beat/cycle sustained).
REQ-026 If m_ready=1 and no beat is accepted, m_valid SHALL go to 0 next cycle.
REQ-027 ptr wrap from NUM_PORTS-1 to 0 SHALL be seamless; NUM_PORTS=1 SHALL degenerate to a registered pass-through with m_src=0.
REQ-028 A requester dropping s_valid mid-packet SHALL NOT release the lock; the arbiter waits in LOCKED.

Reset
REQ-029 While rst=1, s_ready SHALL be all 0 combinationally.
REQ-030 After a clk edge with rst=1: m_valid=0, m_data=0, m_last=0, m_src=0, ptr=0, lock_port=0, state ARB.
REQ-031 Reset mid-packet or with a buffered beat SHALL discard the buffered beat and release any lock.

Verification
REQ-032 Single beats: NUM_PORTS=4, ports 0..3 each present one beat (A0,A1,A2,A3, s_last=1) simultaneously, m_ready=1 -> outputs A0,A1,A2,A3 on consecutive cycles, m_src 0,1,2,3.
REQ-033 Fairness: ports 1 and 3 continuously valid single-beat, m_ready=1 -> m_src alternates 1,3,1,3; ptr wraps 3->0 without skipping port 1.
REQ-034 Packet lock: port 2 sends 3-beat packet (C1,C2,C3 last) while port 0 valid -> m_data C1,C2,C3 with m_src=2, then port 0 beat; no interleave.
REQ-035 Backpressure: m_ready=0 for 5 cycles with m_valid=1, m_data=8'hA5 -> m_data/m_src stable, all s_ready=0; on m_ready=1 next beat 8'hC4 follows next cycle.
REQ-036 Reset mid-packet: rst=1 for 1 cycle after first beat of a locked packet -> m_valid=0, state ARB, ptr=0; port 0 granted first afterward.
REQ-037 Idle: all s_valid=0 -> s_ready all 0, m_valid falls to 0 one cycle after last m_ready handshake.

Source files
------------

// File: rtl/handshake_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : handshake_rr_arbiter
//  Description : Round-robin arbiter that merges NUM_PORTS valid/ready
//                requester streams onto one registered output stream. A
//                packet whose first beat has s_last=0 keeps the grant on
//                its port until the s_last beat has been taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module handshake_rr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [NUM_PORTS-1:0]                              s_valid,
    output logic [NUM_PORTS-1:0]                              s_ready,
    input  logic [NUM_PORTS*DATA_BITS-1:0]                    s_data,
    input  logic [NUM_PORTS-1:0]                              s_last,
    output logic                                              m_valid,
    input  logic                                              m_ready,
    output logic [DATA_BITS-1:0]                              m_data,
    output logic                                              m_last,
    output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] m_src
);

    // Width of a port index; at least one bit so a single-port build still
    // has a legal (constant zero) index.
    localparam int c_PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    // One extra bit so ptr + offset can be reduced modulo NUM_PORTS.
    localparam int c_SUM_W = c_PTR_W + 1;

    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state_q,     state_d;
    logic [c_PTR_W-1:0]   ptr_q,       ptr_d;
    logic [c_PTR_W-1:0]   lock_port_q, lock_port_d;
    logic                 m_valid_q,   m_valid_d;
    logic [DATA_BITS-1:0] m_data_q,    m_data_d;
    logic                 m_last_q,    m_last_d;
    logic [c_PTR_W-1:0]   m_src_q,     m_src_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                 w_can_accept;
    logic                 w_cand_found;
    logic [c_PTR_W-1:0]   w_cand_idx;
    logic                 w_sel_en;
    logic [c_PTR_W-1:0]   w_sel_port;
    logic                 w_sel_valid;
    logic [DATA_BITS-1:0] w_sel_data;
    logic                 w_sel_last;
    logic                 w_accept;

    // Circular successor of a port index.
    function automatic logic [c_PTR_W-1:0] next_idx(input logic [c_PTR_W-1:0] idx);
        if (idx == c_PTR_W'(NUM_PORTS - 1)) begin
            return '0;
        end
        return idx + c_PTR_W'(1);
    endfunction

    // The output register can take a beat when empty or being drained.
    assign w_can_accept = !m_valid_q || m_ready;

    // Round-robin candidate: first valid requester at or after ptr.
    always_comb begin
        logic [c_SUM_W-1:0] sum;
        w_cand_found = 1'b0;
        w_cand_idx   = '0;
        sum          = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            sum = {1'b0, ptr_q} + c_SUM_W'(k);
            if (sum >= c_SUM_W'(NUM_PORTS)) begin
                sum = sum - c_SUM_W'(NUM_PORTS);
            end
            if (!w_cand_found && s_valid[sum[c_PTR_W-1:0]]) begin
                w_cand_found = 1'b1;
                w_cand_idx   = sum[c_PTR_W-1:0];
            end
        end
    end

    // Selected port: the lock holder while locked, else the RR candidate.
    always_comb begin
        w_sel_en   = 1'b0;
        w_sel_port = '0;
        if (state_q == ST_LOCKED) begin
            w_sel_en   = 1'b1;
            w_sel_port = lock_port_q;
        end else begin
            w_sel_en   = w_cand_found;
            w_sel_port = w_cand_idx;
        end
    end

    // One-hot ready toward the selected port and mux of its beat.
    always_comb begin
        s_ready     = '0;
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_sel_port == c_PTR_W'(i)) begin
                s_ready[i]  = !rst && w_sel_en && w_can_accept;
                w_sel_valid = s_valid[i];
                w_sel_data  = s_data[i*DATA_BITS +: DATA_BITS];
                w_sel_last  = s_last[i];
            end
        end
    end

    // A beat is taken only when the selected port is both valid and ready.
    assign w_accept = !rst && w_sel_en && w_can_accept && w_sel_valid;

    // Arbitration FSM: next state, round-robin pointer and lock owner.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        lock_port_d = lock_port_q;
        case (state_q)
            ST_ARB: begin
                if (w_accept) begin
                    if (w_sel_last) begin
                        ptr_d = next_idx(w_cand_idx);
                    end else begin
                        lock_port_d = w_cand_idx;
                        state_d     = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                // A stalled lock holder keeps the lock; only its last beat
                // releases the grant.
                if (w_accept && w_sel_last) begin
                    state_d = ST_ARB;
                    ptr_d   = next_idx(lock_port_q);
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    // Output register: load on accept, otherwise empty once drained.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        m_src_d   = m_src_q;
        if (w_accept) begin
            m_valid_d = 1'b1;
            m_data_d  = w_sel_data;
            m_last_d  = w_sel_last;
            m_src_d   = w_sel_port;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; reset drops any buffered beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ARB;
            ptr_q       <= '0;
            lock_port_q <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            m_src_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lock_port_q <= lock_port_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            m_src_q     <= m_src_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign m_src   = m_src_q;

endmodule
`default_nettype wire

// File: tb/tb_handshake_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_handshake_rr_arbiter
//  Description : Directed bench for handshake_rr_arbiter with per-port
//                source queues and an expected-output scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake_rr_arbiter;

    localparam int NP = 4;
    localparam int DW = 8;

    logic             clk;
    logic             rst;
    logic [NP-1:0]    s_valid;
    logic [NP-1:0]    s_ready;
    logic [NP*DW-1:0] s_data;
    logic [NP-1:0]    s_last;
    logic             m_valid;
    logic             m_ready;
    logic [DW-1:0]    m_data;
    logic             m_last;
    logic [1:0]       m_src;

    handshake_rr_arbiter #(
        .NUM_PORTS (NP),
        .DATA_BITS (DW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_src   (m_src)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Requester beats {last, data} per port and expected outputs {last, src, data}.
    logic [8:0]  srcq [NP][$];
    logic [10:0] expq [$];
    logic [NP-1:0] hs;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic src(input int port, input logic [7:0] d, input logic last);
        srcq[port].push_back({last, d});
    endtask

    task automatic expect_beat(input int port, input logic [7:0] d, input logic last);
        expq.push_back({last, 2'(port), d});
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((expq.size() != 0 || m_valid === 1'b1) && n < 200) begin
            cyc(1);
            n++;
        end
        chk({tag, "_drained"}, 32'(expq.size()), 32'd0);
        chk({tag, "_idle_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_idle_ready"}, 32'(s_ready), 32'd0);
    endtask

    // Requester model: present the head of each source queue, retire on handshake.
    initial begin
        logic [8:0] b;
        s_valid = '0;
        s_data  = '0;
        s_last  = '0;
        forever begin
            @(negedge clk);
            hs = s_valid & s_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NP; i++) begin
                if (hs[i] && srcq[i].size() > 0) begin
                    b = srcq[i].pop_front();
                end
                if (srcq[i].size() > 0) begin
                    b = srcq[i][0];
                    s_valid[i]           = 1'b1;
                    s_data[i*DW +: DW]   = b[7:0];
                    s_last[i]            = b[8];
                end else begin
                    s_valid[i]           = 1'b0;
                    s_data[i*DW +: DW]   = '0;
                    s_last[i]            = 1'b0;
                end
            end
        end
    end

    // Output monitor: every output handshake must match the scoreboard head.
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if (!rst && m_valid && m_ready) begin
                n_assert++;
                assert (expq.size() != 0) else begin
                    n_fail++;
                    $error("FAIL out_unexpected observed=src%0d/0x%0h expected=no beat", m_src, m_data);
                end
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("out_data", 32'(m_data), 32'(e[7:0]));
                    chk("out_src",  32'(m_src),  32'(e[9:8]));
                    chk("out_last", 32'(m_last), 32'(e[10]));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        m_ready = 1'b0;
        cyc(3);

        // Reset state
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data",  32'(m_data),  32'd0);
        chk("rst_m_last",  32'(m_last),  32'd0);
        chk("rst_m_src",   32'(m_src),   32'd0);
        chk("rst_ptr",     32'(dut.ptr_q), 32'd0);
        chk("rst_state",   32'(dut.state_q), 32'd0);

        // Single beats from all four ports, presented while still in reset
        for (int i = 0; i < NP; i++) begin
            src(i, 8'(8'hA0 + i), 1'b1);
            expect_beat(i, 8'(8'hA0 + i), 1'b1);
        end
        cyc(2);
        chk("rst_sready_masked", 32'(s_ready), 32'd0);
        chk("rst_no_output",     32'(m_valid), 32'd0);
        rst     = 1'b0;
        m_ready = 1'b1;
        cyc(1);
        for (int k = 0; k < 4; k++) begin
            chk("single_stream_valid", 32'(m_valid), 32'd1);
            cyc(1);
        end
        chk("single_valid_fall", 32'(m_valid), 32'd0);
        drain("single");

        // Fairness between ports 1 and 3, crossing the pointer wrap
        for (int k = 0; k < 3; k++) begin
            src(1, 8'(8'h10 + k), 1'b1);
            src(3, 8'(8'h30 + k), 1'b1);
            expect_beat(1, 8'(8'h10 + k), 1'b1);
            expect_beat(3, 8'(8'h30 + k), 1'b1);
        end
        drain("fair");

        // Packet lock: move ptr to 2, then port 2 packet against port 0
        src(1, 8'hB1, 1'b1);
        expect_beat(1, 8'hB1, 1'b1);
        drain("lock_pre");
        src(2, 8'hC1, 1'b0);
        src(2, 8'hC2, 1'b0);
        src(2, 8'hC3, 1'b1);
        src(0, 8'hD0, 1'b1);
        expect_beat(2, 8'hC1, 1'b0);
        expect_beat(2, 8'hC2, 1'b0);
        expect_beat(2, 8'hC3, 1'b1);
        expect_beat(0, 8'hD0, 1'b1);
        drain("lock_pkt");

        // Lock holder stalls mid-packet; port 3 must stay ignored
        src(1, 8'hE1, 1'b0);
        src(3, 8'hF3, 1'b1);
        expect_beat(1, 8'hE1, 1'b0);
        cyc(4);
        chk("stall_sready",  32'(s_ready), 32'b0010);
        chk("stall_state",   32'(dut.state_q), 32'd1);
        chk("stall_pending", 32'(srcq[3].size()), 32'd1);
        chk("stall_m_valid", 32'(m_valid), 32'd0);
        src(1, 8'hE2, 1'b1);
        expect_beat(1, 8'hE2, 1'b1);
        expect_beat(3, 8'hF3, 1'b1);
        drain("lock_resume");

        // Backpressure: A5 held for five cycles, C4 follows on release
        m_ready = 1'b0;
        src(0, 8'hA5, 1'b1);
        src(1, 8'hC4, 1'b1);
        expect_beat(0, 8'hA5, 1'b1);
        expect_beat(1, 8'hC4, 1'b1);
        cyc(2);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid",  32'(m_valid), 32'd1);
            chk("bp_data",   32'(m_data),  32'hA5);
            chk("bp_src",    32'(m_src),   32'd0);
            chk("bp_sready", 32'(s_ready), 32'd0);
            cyc(1);
        end
        m_ready = 1'b1;
        cyc(1);
        chk("bp_next_valid", 32'(m_valid), 32'd1);
        chk("bp_next_data",  32'(m_data),  32'hC4);
        chk("bp_next_src",   32'(m_src),   32'd1);
        drain("bp");

        // Reset after the first beat of a locked packet
        m_ready = 1'b0;
        src(2, 8'h61, 1'b0);
        src(0, 8'h70, 1'b1);
        cyc(2);
        chk("mid_state_locked", 32'(dut.state_q), 32'd1);
        chk("mid_m_valid",      32'(m_valid), 32'd1);
        chk("mid_m_data",       32'(m_data),  32'h61);
        chk("mid_m_src",        32'(m_src),   32'd2);
        rst = 1'b1;
        src(2, 8'h69, 1'b1);
        cyc(1);
        chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_state",   32'(dut.state_q), 32'd0);
        chk("mid_rst_ptr",     32'(dut.ptr_q), 32'd0);
        chk("mid_rst_lock",    32'(dut.lock_port_q), 32'd0);
        chk("mid_rst_sready",  32'(s_ready), 32'd0);
        rst     = 1'b0;
        m_ready = 1'b1;
        expect_beat(0, 8'h70, 1'b1);
        expect_beat(2, 8'h69, 1'b1);
        cyc(1);
        chk("post_rst_first_valid", 32'(m_valid), 32'd1);
        chk("post_rst_first_src",   32'(m_src),   32'd0);
        drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
